edu_token_row_2_reg: RTL and testbench
======================================

Name: edu_token_row_2_reg

Overview:
- Registered row-2 token stage of the EDU token network. Sits directly downstream of the combinational row-2 token setup logic.
- Accepts the one-hot token mask `token_set_row_2` and the thermometer flag mask `flag_set_row_2` through a valid/ready handshake.
- Holds the token, then walks it one column per `token_pass` while growing the flag region.
- Reports the current token column and a one-cycle done pulse when the token leaves the last column.

Parameters:
- NUM_AQROW, 8 (from `define.v`), number of ancilla-qubit columns in a row.
- AQROWADDR_BW, 3 (from `define.v`), width of a column address; equals clog2(NUM_AQROW).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- token_set_row_2  input  NUM_AQROW  one-hot token load mask.
- flag_set_row_2  input  NUM_AQROW  thermometer flag load mask; bits 0..col set.
- set_valid  input  1  load request.
- set_ready  output  1  high only in IDLE.
- token_pass  input  1  advance token one column.
- token_clear  input  1  synchronous abort to IDLE.
- token_row_2  output  NUM_AQROW  registered token mask.
- flag_row_2  output  NUM_AQROW  registered flag mask.
- token_exist_row_2  output  1  token_row_2 != 0.
- token_col_row_2  output  AQROWADDR_BW  registered column of the token; 0 when no token.
- token_done  output  1  one-cycle pulse when the token leaves column NUM_AQROW-1.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - token_row_2=0, flag_row_2=0, token_col_row_2=0, token_exist_row_2=0, token_done=0.
  - set_ready=1 once out of reset (IDLE).
- States: IDLE, HOLD, DONE.
- Clear priority: token_clear overrides everything in every state. Next edge returns to IDLE with token/flag/col cleared and token_done=0.
- IDLE:
  - set_ready=1.
  - On set_valid=1 with token_set_row_2 != 0:
    - latch token_row_2 <= token_set_row_2 and flag_row_2 <= flag_set_row_2;
    - token_col_row_2 <= index of lowest set bit of token_set_row_2;
    - go to HOLD.
  - Load latency is 1 cycle; outputs are valid the cycle after acceptance.
  - On set_valid=1 with token_set_row_2 == 0: the load is accepted, the registers are cleared, and the state stays IDLE.
  - Multiple bits set in token_set_row_2: the lowest bit wins. token_row_2 stores only that bit; flag_row_2 is stored as given.
- HOLD:
  - set_ready=0; set_valid is ignored with no side effect.
  - token_pass=1 and col < NUM_AQROW-1:
    - token_row_2 <= token_row_2 << 1;
    - col <= col+1;
    - flag_row_2 <= flag_row_2 | (1 << (col+1)).
  - token_pass=1 and col == NUM_AQROW-1:
    - token_row_2 <= 0, col <= 0, flag_row_2 <= all ones;
    - token_done <= 1; go to DONE.
  - token_pass=0: hold all registers.
- DONE:
  - Lasts exactly one cycle with token_done=1.
  - token_pass and set_valid are ignored.
  - Next edge: token_done <= 0, flag_row_2 <= 0, go to IDLE.
- token_exist_row_2 is derived combinationally from the registered token_row_2.
- No arithmetic wrap: col never increments past NUM_AQROW-1.
- Reset asserted mid-walk aborts immediately, asynchronously, with no done pulse.

Test Plan:
- Reset, then load with token_set_row_2=8'b0000_0100, flag=8'b0000_0111, set_valid=1 for one cycle -> next cycle token_row_2=8'h04, flag_row_2=8'h07, token_col_row_2=2, token_exist_row_2=1, set_ready=0.
- From col 2, hold token_pass=1 for 5 cycles:
  - col steps 3,4,5,6,7; flag steps 0x0F,0x1F,0x3F,0x7F,0xFF.
  - 6th pass -> token_done=1 for exactly one cycle, token_row_2=0, flag_row_2=8'hFF.
  - Next cycle IDLE with flag_row_2=0 and set_ready=1.
- Load with token_set_row_2=0, set_valid=1 -> state stays IDLE, token_exist_row_2=0, set_ready=1, no done pulse.
- In HOLD at col 5, assert set_valid with token_set_row_2=8'h01 and token_pass=0 -> no change (col=5, token_row_2=8'h20).
- In HOLD at col 4, assert token_pass=1 and token_clear=1 in the same cycle -> clear wins: next cycle IDLE, all outputs 0, token_done never asserted.
- Deassert rst_n asynchronously between edges while at col 3 -> outputs go to 0 immediately without waiting for a clock edge. After release, the next load with token_set_row_2=8'h80 yields col=7, and one token_pass produces token_done.

Source files
------------

// File: rtl/edu_token_row_2_if.sv
// Handshake and token/flag bus between the row-2 token setup logic and the
// registered row-2 token stage.
interface edu_token_row_2_reg_if #(
  parameter int NUM_AQROW    = 8,
  parameter int AQROWADDR_BW = 3
);
  logic [NUM_AQROW-1:0]    token_set_row_2;
  logic [NUM_AQROW-1:0]    flag_set_row_2;
  logic                    set_valid;
  logic                    set_ready;
  logic                    token_pass;
  logic                    token_clear;
  logic [NUM_AQROW-1:0]    token_row_2;
  logic [NUM_AQROW-1:0]    flag_row_2;
  logic                    token_exist_row_2;
  logic [AQROWADDR_BW-1:0] token_col_row_2;
  logic                    token_done;

  modport master (
    output token_set_row_2, flag_set_row_2, set_valid, token_pass, token_clear,
    input  set_ready, token_row_2, flag_row_2, token_exist_row_2, token_col_row_2, token_done
  );

  modport slave (
    input  token_set_row_2, flag_set_row_2, set_valid, token_pass, token_clear,
    output set_ready, token_row_2, flag_row_2, token_exist_row_2, token_col_row_2, token_done
  );
endinterface

// File: rtl/edu_token_row_2_reg.sv
// Registered row-2 token stage: loads a token/flag pair, walks the token one
// column per pass while growing the flag region, and pulses done at the end.
module edu_token_row_2_reg #(
  parameter int NUM_AQROW    = 8,
  parameter int AQROWADDR_BW = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  edu_token_row_2_reg_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_e;

  localparam logic [AQROWADDR_BW-1:0] LAST_COL = AQROWADDR_BW'(NUM_AQROW-1);

  state_e                  state_q, state_d;
  logic [NUM_AQROW-1:0]    token_q, token_d;
  logic [NUM_AQROW-1:0]    flag_q, flag_d;
  logic [AQROWADDR_BW-1:0] col_q, col_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;

  logic [NUM_AQROW-1:0]    low_mask;
  logic [AQROWADDR_BW-1:0] low_idx;
  logic [AQROWADDR_BW-1:0] col_inc;

  // Lowest set bit wins when the load mask is not strictly one-hot.
  always_comb begin
    low_mask = bus.token_set_row_2 & (~bus.token_set_row_2 + NUM_AQROW'(1));
    low_idx  = '0;
    for (int i = NUM_AQROW-1; i >= 0; i--)
      if (bus.token_set_row_2[i]) low_idx = AQROWADDR_BW'(i);
  end

  assign col_inc = col_q + AQROWADDR_BW'(1);

  always_comb begin
    state_d = state_q;
    token_d = token_q;
    flag_d  = flag_q;
    col_d   = col_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    if (bus.token_clear) begin
      state_d = IDLE;
      token_d = '0;
      flag_d  = '0;
      col_d   = '0;
      ready_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.set_valid) begin
            token_d = low_mask;
            col_d   = low_idx;
            if (bus.token_set_row_2 != '0) begin
              flag_d  = bus.flag_set_row_2;
              state_d = HOLD;
              ready_d = 1'b0;
            end else begin
              flag_d  = '0;
            end
          end
        end
        HOLD: begin
          if (bus.token_pass) begin
            if (col_q == LAST_COL) begin
              token_d = '0;
              col_d   = '0;
              flag_d  = '1;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              token_d = token_q << 1;
              col_d   = col_inc;
              flag_d  = flag_q | (NUM_AQROW'(1) << col_inc);
            end
          end
        end
        DONE: begin
          flag_d  = '0;
          state_d = IDLE;
          ready_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      token_q <= '0;
      flag_q  <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      token_q <= token_d;
      flag_q  <= flag_d;
      col_q   <= col_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.set_ready         = ready_q;
  assign bus.token_row_2       = token_q;
  assign bus.flag_row_2        = flag_q;
  assign bus.token_col_row_2   = col_q;
  assign bus.token_done        = done_q;
  assign bus.token_exist_row_2 = |token_q;
endmodule

// File: tb/tb_edu_token_row_2_reg.sv
// Directed bench for the registered row-2 token stage.
module tb_edu_token_row_2_reg;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  edu_token_row_2_reg_if #(.NUM_AQROW(8), .AQROWADDR_BW(3)) bus ();

  edu_token_row_2_reg #(.NUM_AQROW(8), .AQROWADDR_BW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {token, flag, col, exist, ready, done}
  logic [21:0] obs;
  assign obs = {bus.token_row_2, bus.flag_row_2, bus.token_col_row_2,
                bus.token_exist_row_2, bus.set_ready, bus.token_done};

  function automatic logic [21:0] exp_of(input logic [7:0] tok, input logic [7:0] flg,
                                         input logic [2:0] col, input logic ex,
                                         input logic rdy, input logic dn);
    return {tok, flg, col, ex, rdy, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] tok, input logic [7:0] flg);
    bus.token_set_row_2 = tok;
    bus.flag_set_row_2  = flg;
    bus.set_valid       = 1'b1;
    tick();
    bus.set_valid       = 1'b0;
    bus.token_set_row_2 = '0;
    bus.flag_set_row_2  = '0;
  endtask

  task automatic clear_out();
    bus.token_clear = 1'b1;
    tick();
    bus.token_clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] e;
    rst_n = 1'b0;
    bus.token_set_row_2 = '0;
    bus.flag_set_row_2  = '0;
    bus.set_valid       = 1'b0;
    bus.token_pass      = 1'b0;
    bus.token_clear     = 1'b0;
    #23;
    rst_n = 1'b1;
    tick();
    e = exp_of(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL reset obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_load_and_walk();
    logic [21:0] e;
    load(8'b0000_0100, 8'b0000_0111);
    e = exp_of(8'h04, 8'h07, 3'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL load obs=%h exp=%h", obs, e); end
    bus.token_pass = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int c;
      tick();
      c = 3 + k;
      e = exp_of(8'(1 << c), 8'((1 << (c + 1)) - 1), 3'(c), 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin failures++; $display("FAIL walk col%0d obs=%h exp=%h", c, obs, e); end
    end
    tick();
    bus.token_pass = 1'b0;
    e = exp_of(8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL walk_done obs=%h exp=%h", obs, e); end
    tick();
    e = exp_of(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL walk_idle obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_zero_load();
    logic [21:0] e;
    load(8'h00, 8'h5A);
    e = exp_of(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL zero_load obs=%h exp=%h", obs, e); end
    tick();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL zero_load_idle obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_multi_bit();
    logic [21:0] e;
    load(8'b0000_1100, 8'h07);
    e = exp_of(8'h04, 8'h07, 3'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL multi_bit obs=%h exp=%h", obs, e); end
    clear_out();
  endtask

  task automatic test_hold_ignore();
    logic [21:0] e;
    load(8'h20, 8'h3F);
    bus.set_valid       = 1'b1;
    bus.token_set_row_2 = 8'h01;
    bus.flag_set_row_2  = 8'h01;
    bus.token_pass      = 1'b0;
    tick();
    tick();
    bus.set_valid       = 1'b0;
    bus.token_set_row_2 = '0;
    bus.flag_set_row_2  = '0;
    e = exp_of(8'h20, 8'h3F, 3'd5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL hold_ignore obs=%h exp=%h", obs, e); end
    clear_out();
    e = exp_of(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL hold_clear obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_clear_priority();
    logic [21:0] e;
    load(8'h10, 8'h1F);
    e = exp_of(8'h10, 8'h1F, 3'd4, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL clear_load obs=%h exp=%h", obs, e); end
    bus.token_pass  = 1'b1;
    bus.token_clear = 1'b1;
    tick();
    bus.token_pass  = 1'b0;
    bus.token_clear = 1'b0;
    e = exp_of(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL clear_prio obs=%h exp=%h", obs, e); end
    tick();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL clear_no_done obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_async_reset();
    logic [21:0] e;
    load(8'h08, 8'h0F);
    e = exp_of(8'h08, 8'h0F, 3'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL async_pre obs=%h exp=%h", obs, e); end
    #2;
    rst_n = 1'b0;
    #1;
    e = exp_of(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL async_rst obs=%h exp=%h", obs, e); end
    #3;
    rst_n = 1'b1;
    tick();
    load(8'h80, 8'hFF);
    e = exp_of(8'h80, 8'hFF, 3'd7, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL async_reload obs=%h exp=%h", obs, e); end
    bus.token_pass = 1'b1;
    tick();
    bus.token_pass = 1'b0;
    e = exp_of(8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL async_done obs=%h exp=%h", obs, e); end
    tick();
    e = exp_of(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL async_idle obs=%h exp=%h", obs, e); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_load_and_walk();
    test_zero_load();
    test_multi_bit();
    test_hold_ignore();
    test_clear_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
